// File: rtl/gf180mcu_osu_sc_gp9t3v3__tiectl.sv
// rtl/gf180mcu_osu_sc_gp9t3v3__tiectl.sv - serially loaded programmable tie-off register
// Optional even-parity check on each load: define GF180MCU_OSU_SC_TIECTL_PARITY_EN.
module gf180mcu_osu_sc_gp9t3v3__tiectl #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ABORT,
   input  logic             SEN,
   input  logic             SDI,
   output logic             SDO,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [WIDTH-1:0] Y
);

`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int            CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [NB-1:0]  shreg;

   assign SDO = shreg[0];

`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
   logic err_q;
   logic parity_ok;

   // The parity bit arrives last, so it sits in the MSB above the data bits.
   assign parity_ok = ((^shreg[WIDTH-1:0]) == shreg[WIDTH]);
   assign ERR       = err_q;
`else
   assign ERR = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state <= ST_IDLE;
         cnt   <= '0;
         shreg <= '0;
         Y     <= RESET_VAL;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
         err_q <= 1'b0;
`endif
      end else begin
         DONE  <= 1'b0;
`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
         err_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (START && !ABORT) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (ABORT) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end else if (SEN) begin
                  shreg <= {SDI, shreg[NB-1:1]};
                  cnt   <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state <= ST_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               // Abort wins over commit; Y stays put and neither pulse fires.
               state <= ST_IDLE;
               BUSY  <= 1'b0;
               if (!ABORT) begin
`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
                  if (parity_ok) begin
                     Y    <= shreg[WIDTH-1:0];
                     DONE <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
`else
                  Y    <= shreg[WIDTH-1:0];
                  DONE <= 1'b1;
`endif
               end
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__tiectl.sv
// tb/tb_gf180mcu_osu_sc_gp9t3v3__tiectl.sv - directed self-checking bench for the tie-off controller
module tb_gf180mcu_osu_sc_gp9t3v3__tiectl;

   logic        CLK = 1'b0;
   logic        RN, START, ABORT, SEN, SDI;
   logic        SDO, BUSY, DONE, ERR;
   logic [15:0] Y;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] y_cur;

`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
   localparam int NBITS = 17;
`else
   localparam int NBITS = 16;
`endif

   typedef struct {
      logic [15:0] data;
      logic        par;
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_y;
   } vec_t;

   vec_t vecs[6];

   always #5 CLK = ~CLK;

   gf180mcu_osu_sc_gp9t3v3__tiectl #(
      .WIDTH    (16),
      .RESET_VAL(16'hFFFF)
   ) dut (
      .CLK  (CLK),
      .RN   (RN),
      .START(START),
      .ABORT(ABORT),
      .SEN  (SEN),
      .SDI  (SDI),
      .SDO  (SDO),
      .BUSY (BUSY),
      .DONE (DONE),
      .ERR  (ERR),
      .Y    (Y)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SEN/SDI are held high during the START cycle: that cycle must capture nothing.
   task automatic begin_load(input string tag);
      START = 1'b1;
      SEN   = 1'b1;
      SDI   = 1'b1;
      step();
      START = 1'b0;
      SEN   = 1'b0;
      check1({tag, " busy after start"}, BUSY, 1'b1);
   endtask

   task automatic shift_range(input logic [16:0] bits, input int from, input int upto,
                              input int gap_at, input int gap_len, input string tag);
      for (int i = from; i < upto; i++) begin
         if (i == gap_at) begin
            SEN = 1'b0;
            for (int k = 0; k < gap_len; k++) begin
               step();
               check1({tag, " stall busy"}, BUSY, 1'b1);
               check16({tag, " stall y"}, Y, y_cur);
            end
         end
         SEN = 1'b1;
         SDI = bits[i];
         step();
      end
      SEN = 1'b0;
   endtask

   // Called right after the last shift edge; SEN is kept high through COMMIT.
   task automatic finish_commit(input logic [15:0] data, input logic exp_done, input logic exp_err,
                                input logic [15:0] exp_y, input string tag);
      check1({tag, " commit busy"}, BUSY, 1'b1);
      check1({tag, " commit done early"}, DONE, 1'b0);
      check16({tag, " y before commit"}, Y, y_cur);
      check1({tag, " sdo"}, SDO, data[0]);
      SEN = 1'b1;
      SDI = ~data[0];
      step();
      SEN = 1'b0;
      check16({tag, " y after commit"}, Y, exp_y);
      check1({tag, " done pulse"}, DONE, exp_done);
      check1({tag, " err pulse"}, ERR, exp_err);
      check1({tag, " busy after commit"}, BUSY, 1'b0);
      step();
      check1({tag, " done one cycle"}, DONE, 1'b0);
      check1({tag, " err one cycle"}, ERR, 1'b0);
      check16({tag, " y holds"}, Y, exp_y);
      y_cur = exp_y;
   endtask

   task automatic full_load(input logic [15:0] data, input logic par, input logic exp_done,
                            input logic exp_err, input logic [15:0] exp_y,
                            input int gap_at, input int gap_len, input string tag);
      begin_load(tag);
      shift_range({par, data}, 0, NBITS, gap_at, gap_len, tag);
      finish_commit(data, exp_done, exp_err, exp_y, tag);
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 1'b0, 16'hA5C3};
      vecs[1] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hFFFF};
      vecs[3] = '{16'h8001, 1'b0, 1'b1, 1'b0, 16'h8001};
`ifdef GF180MCU_OSU_SC_TIECTL_PARITY_EN
      vecs[4] = '{16'h0001, 1'b0, 1'b0, 1'b1, 16'h8001};
`else
      vecs[4] = '{16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001};
`endif
      vecs[5] = '{16'h0001, 1'b1, 1'b1, 1'b0, 16'h0001};

      RN = 1'b0; START = 1'b0; ABORT = 1'b0; SEN = 1'b0; SDI = 1'b0;
      step();
      step();
      check16("reset y", Y, 16'hFFFF);
      check1("reset busy", BUSY, 1'b0);
      check1("reset done", DONE, 1'b0);
      check1("reset err", ERR, 1'b0);
      check1("reset sdo", SDO, 1'b0);
      RN = 1'b1;
      step();
      check16("post reset y", Y, 16'hFFFF);
      check1("post reset busy", BUSY, 1'b0);
      y_cur = 16'hFFFF;

      for (int v = 0; v < 6; v++) begin
         full_load(vecs[v].data, vecs[v].par, vecs[v].exp_done, vecs[v].exp_err,
                   vecs[v].exp_y, -1, 0, $sformatf("vec%0d", v));
      end

      full_load(16'h3C5A, 1'b0, 1'b1, 1'b0, 16'h3C5A, 8, 5, "stall");

      begin_load("abort");
      shift_range({1'b1, 16'h1234}, 0, 9, -1, 0, "abort");
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      check1("abort busy", BUSY, 1'b0);
      check1("abort done", DONE, 1'b0);
      check1("abort err", ERR, 1'b0);
      check16("abort y", Y, y_cur);
      SEN = 1'b1;
      step();
      SEN = 1'b0;
      check1("abort stays idle", BUSY, 1'b0);
      full_load(16'h1234, 1'b1, 1'b1, 1'b0, 16'h1234, -1, 0, "reload");

      begin_load("abort commit");
      shift_range({1'b0, 16'h00FF}, 0, NBITS, -1, 0, "abort commit");
      check1("abort commit busy", BUSY, 1'b1);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      check16("abort commit y", Y, 16'h1234);
      check1("abort commit done", DONE, 1'b0);
      check1("abort commit err", ERR, 1'b0);
      check1("abort commit busy low", BUSY, 1'b0);

      START = 1'b1;
      ABORT = 1'b1;
      step();
      START = 1'b0;
      ABORT = 1'b0;
      check1("start+abort idle", BUSY, 1'b0);
      step();
      check1("start+abort stays idle", BUSY, 1'b0);

      begin_load("reset mid");
      shift_range({1'b0, 16'h5555}, 0, 7, -1, 0, "reset mid");
      RN = 1'b0;
      step();
      RN = 1'b1;
      check16("reset mid y", Y, 16'hFFFF);
      check1("reset mid busy", BUSY, 1'b0);
      check1("reset mid sdo", SDO, 1'b0);
      step();
      check1("reset mid idle", BUSY, 1'b0);
      y_cur = 16'hFFFF;

      begin_load("start busy");
      shift_range({1'b0, 16'h0F0F}, 0, 5, -1, 0, "start busy");
      START = 1'b1;
      shift_range({1'b0, 16'h0F0F}, 5, 6, -1, 0, "start busy");
      START = 1'b0;
      shift_range({1'b0, 16'h0F0F}, 6, NBITS, -1, 0, "start busy");
      finish_commit(16'h0F0F, 1'b1, 1'b0, 16'h0F0F, "start busy");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
